sync_buf: RTL
=============

Name: sync_buf

Overview:
- Join stage that sits directly downstream of the broadcast block.
- Takes SIZE independent dti branches, typically the re-converging outputs of per-branch processing fed by the broadcast, and holds each branch's transfer in its own one-entry slot.
- Emits a single concatenated dti transfer once every branch has delivered.
- Absorbs per-branch skew, so slow and fast branches re-align without combinational valid coupling between inputs.

Parameters:
- SIZE, 2, number of input branches (>=1).
- DIN_W, 16, data width of each input branch.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- din  dti.consumer  array [SIZE-1:0], data DIN_W each  input branches (valid/ready/data).
- dout  dti.producer  data SIZE*DIN_W  joined output; din[i] data occupies bits [i*DIN_W +: DIN_W].

Behaviour:
- State per branch i: full[i] (1 bit) and slot[i] (DIN_W bits). No other state.
- Reset (rst=1 at posedge): full[i]<=0 for all i. slot contents are don't-care. The reset value of dout.valid is therefore 0. din[i].ready is 1 after reset.
- Output: dout.valid = &full; dout.data = {slot[SIZE-1],...,slot[0]}. Both are driven purely from registers.
- fire_out = dout.valid & dout.ready.
- Input ready (default): din[i].ready = !full[i] | fire_out.
- Accept: acc[i] = din[i].valid & din[i].ready. On acc[i], slot[i]<=din[i].data and full[i]<=1.
- Release: on fire_out with no acc[i], full[i]<=0. On fire_out with acc[i] in the same cycle, full[i] stays 1 and the slot reloads (back-to-back).
- Latency: the last branch accepted at cycle N gives dout.valid=1 at cycle N+1. There is no combinational din.valid->dout.valid path.
- Throughput: 1 join per cycle when all branches are continuously valid and dout.ready=1.
- A full branch holds (ready=0) while any other branch is empty, or while dout.ready=0.
- dout.valid, once asserted, stays 1 and dout.data stays stable until fire_out (dti rule).
- din[i].valid may drop without a transfer. The block never samples a branch without acc[i].
- SIZE=1 degenerates to a one-entry pipeline register.
- Reset mid-operation: all held slots are discarded, no output is produced for them, and dout.valid=0 on the following cycle.

Optional Feature:
- Macro: SYNC_BUF_READY_CUT_EN.
- Defined: din[i].ready = !full[i] only. This removes the dout.ready->din.ready combinational path for timing closure. Consequences:
  - Simultaneous release and reload never occurs.
  - Throughput is 1 join per 2 cycles.
  - Latency is unchanged (1 cycle).
- Undefined: ready follows the default rule above.

Decomposition:
- Package sync_buf_pkg holds:
  - a localparam function for the output width (SIZE*DIN_W);
  - a typedef for the slot record (full flag + data), parameterised via a width constant.
- One sub-module is natural: sync_buf_slot. It is a single-branch one-entry holding register with ports clk, rst, din (dti.consumer), release, full, data. It is instantiated SIZE times in a generate loop.
- Top level keeps only the &full reduction, concatenation and fire_out.

Test Plan:
- Reset: hold rst 3 cycles with all din valid.
  - During rst, dout.valid=0.
  - First cycle after rst, din[i].ready=1 for all i and dout.valid still 0.
- Skew: SIZE=3, DIN_W=8; din[0]=0x11 at cycle 1, din[2]=0x33 at cycle 2, din[1]=0x22 at cycle 4; dout.ready=1.
  - din[0].ready=0 during cycles 2-4.
  - dout.valid=1 only at cycle 5 with data 0x332211, then 0 at cycle 6.
- Streaming: SIZE=2, all valid every cycle with incrementing data 0..9, dout.ready=1.
  - 10 joins on 10 consecutive cycles, data {k,k}.
  - With SYNC_BUF_READY_CUT_EN: 10 joins in 20 cycles.
- Backpressure: all slots full, dout.ready=0 for 4 cycles.
  - dout.data is stable and dout.valid=1.
  - All din[i].ready=0.
  - On dout.ready=1, new data is accepted in the same cycle (default build).
- Valid withdrawal: din[1] asserts valid with 0xAA for one cycle while its slot is full, then deasserts.
  - 0xAA is never captured and never appears on dout.
- Mid-operation reset: 2 of 3 slots full; pulse rst for 1 cycle; then supply only din[2].
  - dout.valid stays 0, proving the earlier slots were flushed.

Source files
------------

// File: rtl/sync_buf_pkg.sv
// Shared widths, slot record and helpers for the sync_buf join stage.
package sync_buf_pkg;

  // Default data width of a single branch slot record.
  localparam int unsigned SLOT_W = 16;

  // One branch slot: occupancy flag plus held data.
  typedef struct packed {
    logic              full;
    logic [SLOT_W-1:0] data;
  } slot_t;

  // Width of the joined output word.
  function automatic int unsigned out_width(input int unsigned size, input int unsigned din_w);
    return size * din_w;
  endfunction

endpackage

// File: rtl/sync_buf_slot.sv
// Single-branch one-entry holding register for the sync_buf join stage.
// SYNC_BUF_READY_CUT_EN: ready depends only on local occupancy (no release bypass).
module sync_buf_slot #(
  parameter int unsigned DIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [DIN_W-1:0] din_data,
  input  logic             rel,
  output logic             full,
  output logic [DIN_W-1:0] data
);

  logic acc;

  // Ready: empty slot, or a slot being drained by the joined output this cycle.
  always_comb begin
`ifdef SYNC_BUF_READY_CUT_EN
    din_ready = !full;
`else
    din_ready = !full | rel;
`endif
    acc = din_valid & din_ready;
  end

  // Occupancy: accept wins over release so back-to-back reloads keep the slot full.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
    end else if (acc) begin
      full <= 1'b1;
    end else if (rel) begin
      full <= 1'b0;
    end
  end

  // Payload capture: only sampled on an accepted transfer.
  always_ff @(posedge clk) begin
    if (acc) begin
      data <= din_data;
    end
  end

endmodule

// File: rtl/sync_buf.sv
// sync_buf: joins SIZE independent valid/ready branches into one concatenated transfer.
// Optional macro SYNC_BUF_READY_CUT_EN removes the dout_ready -> din_ready path
// (half throughput, same latency).
module sync_buf
  import sync_buf_pkg::*;
#(
  parameter int unsigned SIZE  = 2,
  parameter int unsigned DIN_W = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [SIZE-1:0]                      din_valid,
  output logic [SIZE-1:0]                      din_ready,
  input  logic [out_width(SIZE, DIN_W)-1:0]    din_data,
  output logic                                 dout_valid,
  input  logic                                 dout_ready,
  output logic [out_width(SIZE, DIN_W)-1:0]    dout_data
);

  localparam int unsigned OUT_W = out_width(SIZE, DIN_W);

  logic [SIZE-1:0]  full;
  logic [OUT_W-1:0] slot_data;
  logic             fire_out;

  // Join: output is valid only once every branch slot holds data.
  always_comb begin
    dout_valid = &full;
    dout_data  = slot_data;
    fire_out   = dout_valid & dout_ready;
  end

  // One holding slot per branch; branch i maps to bits [i*DIN_W +: DIN_W].
  for (genvar i = 0; i < SIZE; i++) begin : g_slot
    sync_buf_slot #(
      .DIN_W (DIN_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .din_valid (din_valid[i]),
      .din_ready (din_ready[i]),
      .din_data  (din_data[i*DIN_W +: DIN_W]),
      .rel       (fire_out),
      .full      (full[i]),
      .data      (slot_data[i*DIN_W +: DIN_W])
    );
  end

endmodule
